// File: rtl/module_fetch_ctrl_pkg.sv
// Shared types for the fetch sequencer: module_PC operation codes, instruction
// opcodes and sequencer states.
package pkg_fetch;

    localparam int OPC_W = 3;

    typedef enum logic [1:0] {
        PC_RST  = 2'b00,
        PC_HOLD = 2'b01,
        PC_INC  = 2'b10,
        PC_JMP  = 2'b11
    } pc_op_t;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 3'b000,
        OP_JMP  = 3'b001,
        OP_CALL = 3'b010,
        OP_RET  = 3'b011,
        OP_WAIT = 3'b100,
        OP_HALT = 3'b101,
        OP_IL6  = 3'b110,
        OP_IL7  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_DEC,
        S_WAIT,
        S_HALT
    } state_t;

endpackage

// File: rtl/module_fetch_ctrl_rom.sv
// Instruction ROM: contents come from a flat image parameter, combinational
// address decode, registered read gated by en.
module module_rom_instr
    import pkg_fetch::*;
#(
    parameter int ANCHO = 8,
    parameter logic [(OPC_W+ANCHO)*(2**(ANCHO-2))-1:0] ROM_IMAGE = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [ANCHO-3:0]       addr,
    output logic [OPC_W+ANCHO-1:0] data_o
);

    localparam int W = OPC_W + ANCHO;

    logic [W-1:0] rom_word;

    assign rom_word = ROM_IMAGE[int'(addr)*W +: W];

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_o <= '0;
        end else if (en) begin
            data_o <= rom_word;
        end
    end

endmodule

// File: rtl/module_fetch_ctrl.sv
// Fetch sequencer that drives module_PC: fetches from the instruction ROM,
// decodes, and issues pc_op / jump target back to the PC block.
module module_fetch_ctrl
    import pkg_fetch::*;
#(
    parameter int ANCHO = 8,
    parameter logic [(OPC_W+ANCHO)*(2**(ANCHO-2))-1:0] ROM_IMAGE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_i,
    input  logic             restart_i,
    input  logic [ANCHO-1:0] pc_i,
    input  logic [ANCHO-1:0] pcinc_i,
    output logic [1:0]       pc_op_o,
    output logic [ANCHO-1:0] pc_tgt_o,
    output logic [ANCHO-1:0] link_o,
    output logic             halted_o,
    output logic             err_o
);

    state_t                   state;
    logic [OPC_W+ANCHO-1:0]   instr_q;
    logic [ANCHO-1:0]         link_q;
    logic [ANCHO-1:0]         cnt;
    logic                     err_q;
    opcode_t                  opc;
    logic [ANCHO-1:0]         arg;
    pc_op_t                   pc_op;
    logic [ANCHO-1:0]         pc_tgt;
    logic [1:0]               unused_pc_lsb;

    assign unused_pc_lsb = pc_i[1:0];

    module_rom_instr #(
        .ANCHO     (ANCHO),
        .ROM_IMAGE (ROM_IMAGE)
    ) u_rom (
        .clk    (clk),
        .reset  (reset),
        .en     ((state == S_FETCH) && run_i),
        .addr   (pc_i[ANCHO-1:2]),
        .data_o (instr_q)
    );

    assign opc = opcode_t'(instr_q[ANCHO+OPC_W-1:ANCHO]);
    assign arg = instr_q[ANCHO-1:0];

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        pc_op  = PC_HOLD;
        pc_tgt = '0;
        case (state)
            S_RST: pc_op = PC_RST;
            S_DEC: begin
                case (opc)
                    OP_NOP:  pc_op = PC_INC;
                    OP_JMP,
                    OP_CALL: begin
                        pc_op  = PC_JMP;
                        pc_tgt = arg;
                    end
                    OP_RET: begin
                        pc_op  = PC_JMP;
                        pc_tgt = link_q;
                    end
                    OP_WAIT: if (arg == '0) pc_op = PC_INC;
                    default: pc_op = PC_HOLD;
                endcase
            end
            // cnt counts down to zero; the zero cycle releases the PC.
            S_WAIT: if (cnt == '0) pc_op = PC_INC;
            default: pc_op = PC_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_RST;
            link_q <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else if (restart_i) begin
            state  <= S_RST;
            link_q <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_RST:   state <= S_FETCH;
                S_FETCH: if (run_i) state <= S_DEC;
                S_DEC: begin
                    case (opc)
                        OP_NOP, OP_JMP, OP_RET: state <= S_FETCH;
                        OP_CALL: begin
                            link_q <= pcinc_i;
                            state  <= S_FETCH;
                        end
                        OP_WAIT: begin
                            if (arg == '0) begin
                                state <= S_FETCH;
                            end else begin
                                cnt   <= arg;
                                state <= S_WAIT;
                            end
                        end
                        OP_HALT: state <= S_HALT;
                        default: begin
                            err_q <= 1'b1;
                            state <= S_HALT;
                        end
                    endcase
                end
                S_WAIT: begin
                    if (cnt == '0) state <= S_FETCH;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= state;
            endcase
        end
    end

    assign pc_op_o  = pc_op;
    assign pc_tgt_o = pc_tgt;
    assign link_o   = link_q;
    assign halted_o = (state == S_HALT);
    assign err_o    = err_q;

endmodule

// File: tb/tb_module_fetch_ctrl.sv
// Directed bench: the fetch sequencer closed around a small behavioural PC
// block, walking a fixed program through every opcode and the control inputs.
module tb_module_fetch_ctrl;

    localparam int A     = 8;
    localparam int W     = 3 + A;
    localparam int DEPTH = 2 ** (A - 2);

    function automatic logic [W-1:0] enc(input logic [2:0] op, input logic [A-1:0] a);
        return {op, a};
    endfunction

    // Program: 0 NOP, 4 NOP, 8 JMP 0x20, 0x20 CALL 0x40, 0x40 RET,
    // 0x24 WAIT 3, 0x28 WAIT 0, 0x2C HALT, 0x30 illegal 110.
    function automatic logic [W*DEPTH-1:0] build_image();
        logic [W*DEPTH-1:0] img;
        img = '0;
        img[0*W  +: W] = enc(3'b000, 8'h00);
        img[1*W  +: W] = enc(3'b000, 8'h00);
        img[2*W  +: W] = enc(3'b001, 8'h20);
        img[8*W  +: W] = enc(3'b010, 8'h40);
        img[16*W +: W] = enc(3'b011, 8'h00);
        img[9*W  +: W] = enc(3'b100, 8'h03);
        img[10*W +: W] = enc(3'b100, 8'h00);
        img[11*W +: W] = enc(3'b101, 8'h00);
        img[12*W +: W] = enc(3'b110, 8'h00);
        return img;
    endfunction

    localparam logic [W*DEPTH-1:0] IMAGE = build_image();

    logic         clk = 1'b0;
    logic         rst_n;
    logic         run_i;
    logic         restart_i;
    logic [A-1:0] pc;
    logic [A-1:0] pcinc;
    logic [1:0]   pc_op_o;
    logic [A-1:0] pc_tgt_o;
    logic [A-1:0] link_o;
    logic         halted_o;
    logic         err_o;
    logic         force_en;
    logic [A-1:0] force_val;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    module_fetch_ctrl #(
        .ANCHO     (A),
        .ROM_IMAGE (IMAGE)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .run_i     (run_i),
        .restart_i (restart_i),
        .pc_i      (pc),
        .pcinc_i   (pcinc),
        .pc_op_o   (pc_op_o),
        .pc_tgt_o  (pc_tgt_o),
        .link_o    (link_o),
        .halted_o  (halted_o),
        .err_o     (err_o)
    );

    // Behavioural module_PC; force_en lets the bench place the PC directly.
    assign pcinc = pc + 8'd4;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pc <= '0;
        else if (force_en) pc <= force_val;
        else begin
            case (pc_op_o)
                2'b00:   pc <= '0;
                2'b10:   pc <= pcinc;
                2'b11:   pc <= pc_tgt_o;
                default: pc <= pc;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic place_pc(input logic [A-1:0] v);
        run_i     = 1'b0;
        force_en  = 1'b1;
        force_val = v;
        tick();
        force_en  = 1'b0;
        run_i     = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (pc_op_o !== 2'b00) $display("FAIL reset_op got %b want 00", pc_op_o); else n_pass++;
        n_checks++; if ({pc_tgt_o, link_o, halted_o, err_o} !== '0)
            $display("FAIL reset_outs got tgt=%h link=%h halt=%b err=%b want all 0", pc_tgt_o, link_o, halted_o, err_o);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (pc_op_o !== 2'b00) $display("FAIL rst_state_op got %b want 00", pc_op_o); else n_pass++;
    endtask

    task automatic test_nop_seq();
        logic [1:0] exp_op [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0] exp_pc [4] = '{8'h00, 8'h00, 8'h04, 8'h04};
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (pc_op_o !== exp_op[i] || pc !== exp_pc[i])
                $display("FAIL nop_seq[%0d] got op=%b pc=%h want op=%b pc=%h", i, pc_op_o, pc, exp_op[i], exp_pc[i]);
            else n_pass++;
        end
        tick();
        n_checks++; if (pc !== 8'h08 || pc_op_o !== 2'b01) $display("FAIL nop_pc8 got pc=%h op=%b want 08/01", pc, pc_op_o); else n_pass++;
    endtask

    task automatic test_jmp();
        tick();
        n_checks++; if (pc_op_o !== 2'b11 || pc_tgt_o !== 8'h20)
            $display("FAIL jmp_dec got op=%b tgt=%h want 11/20", pc_op_o, pc_tgt_o);
        else n_pass++;
        tick();
        n_checks++; if (pc !== 8'h20) $display("FAIL jmp_pc got %h want 20", pc); else n_pass++;
    endtask

    task automatic test_call_ret();
        tick();
        n_checks++; if (pc_op_o !== 2'b11 || pc_tgt_o !== 8'h40)
            $display("FAIL call_dec got op=%b tgt=%h want 11/40", pc_op_o, pc_tgt_o);
        else n_pass++;
        tick();
        n_checks++; if (pc !== 8'h40 || link_o !== 8'h24)
            $display("FAIL call_link got pc=%h link=%h want 40/24", pc, link_o);
        else n_pass++;
        tick();
        n_checks++; if (pc_op_o !== 2'b11 || pc_tgt_o !== 8'h24)
            $display("FAIL ret_dec got op=%b tgt=%h want 11/24", pc_op_o, pc_tgt_o);
        else n_pass++;
        tick();
        n_checks++; if (pc !== 8'h24) $display("FAIL ret_pc got %h want 24", pc); else n_pass++;
    endtask

    task automatic test_wait();
        int bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pc_op_o !== 2'b01 || pc_tgt_o !== 8'h00 || pc !== 8'h24) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL wait3_hold got %0d bad cycles want 0", bad); else n_pass++;
        tick();
        n_checks++; if (pc_op_o !== 2'b10) $display("FAIL wait3_release got op=%b want 10", pc_op_o); else n_pass++;
        tick();
        n_checks++; if (pc !== 8'h28 || pc_op_o !== 2'b01) $display("FAIL wait3_next got pc=%h op=%b want 28/01", pc, pc_op_o); else n_pass++;
        tick();
        n_checks++; if (pc_op_o !== 2'b10) $display("FAIL wait0_dec got op=%b want 10", pc_op_o); else n_pass++;
        tick();
        n_checks++; if (pc !== 8'h2c || pc_op_o !== 2'b01) $display("FAIL wait0_next got pc=%h op=%b want 2c/01", pc, pc_op_o); else n_pass++;
    endtask

    task automatic test_halt_restart();
        int bad = 0;
        tick();
        n_checks++; if (pc_op_o !== 2'b01 || halted_o !== 1'b0) $display("FAIL halt_dec got op=%b halt=%b want 01/0", pc_op_o, halted_o); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pc_op_o !== 2'b01 || halted_o !== 1'b1 || pc !== 8'h2c || err_o !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL halt_hold got %0d bad cycles want 0", bad); else n_pass++;
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        n_checks++; if (pc_op_o !== 2'b00 || halted_o !== 1'b0 || link_o !== 8'h00)
            $display("FAIL restart got op=%b halt=%b link=%h want 00/0/00", pc_op_o, halted_o, link_o);
        else n_pass++;
        tick();
        n_checks++; if (pc !== 8'h00 || pc_op_o !== 2'b01) $display("FAIL restart_pc got pc=%h op=%b want 00/01", pc, pc_op_o); else n_pass++;
    endtask

    task automatic test_stall_illegal();
        int bad = 0;
        run_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pc_op_o !== 2'b01 || pc !== 8'h00) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL stall got %0d bad cycles want 0", bad); else n_pass++;
        place_pc(8'h30);
        tick();
        n_checks++; if (pc_op_o !== 2'b01 || pc_tgt_o !== 8'h00 || err_o !== 1'b0)
            $display("FAIL illegal_dec got op=%b tgt=%h err=%b want 01/00/0", pc_op_o, pc_tgt_o, err_o);
        else n_pass++;
        tick();
        n_checks++; if (err_o !== 1'b1 || halted_o !== 1'b1) $display("FAIL illegal_err got err=%b halt=%b want 1/1", err_o, halted_o); else n_pass++;
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        n_checks++; if (err_o !== 1'b0 || halted_o !== 1'b0 || pc_op_o !== 2'b00)
            $display("FAIL err_clear got err=%b halt=%b op=%b want 0/0/00", err_o, halted_o, pc_op_o);
        else n_pass++;
        tick();
        place_pc(8'h40);
        tick();
        n_checks++; if (pc_op_o !== 2'b11 || pc_tgt_o !== 8'h00)
            $display("FAIL ret_nocall got op=%b tgt=%h want 11/00", pc_op_o, pc_tgt_o);
        else n_pass++;
        tick();
        n_checks++; if (pc !== 8'h00) $display("FAIL ret_nocall_pc got %h want 00", pc); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        place_pc(8'h24);
        tick();
        tick();
        n_checks++; if (pc_op_o !== 2'b01) $display("FAIL pre_reset_wait got op=%b want 01", pc_op_o); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (pc_op_o !== 2'b00 || {pc_tgt_o, link_o, halted_o, err_o} !== '0)
            $display("FAIL async_reset got op=%b tgt=%h link=%h halt=%b err=%b want 00/0", pc_op_o, pc_tgt_o, link_o, halted_o, err_o);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if (pc !== 8'h00 || pc_op_o !== 2'b01) $display("FAIL post_reset got pc=%h op=%b want 00/01", pc, pc_op_o); else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        run_i     = 1'b1;
        restart_i = 1'b0;
        force_en  = 1'b0;
        force_val = '0;
        test_reset();
        test_nop_seq();
        test_jmp();
        test_call_ret();
        test_wait();
        test_halt_restart();
        test_stall_illegal();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
